// File: rtl/ws_systolic_array_if.sv
// Weight-load, input-vector and result bus of ws_systolic_array.
// The master drives weights and vectors; the array is the slave.
interface ws_systolic_array_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic                   wt_valid;
    logic                   wt_ready;
    logic [COLS*DATA_W-1:0] wt_row;
    logic                   in_valid;
    logic                   in_ready;
    logic [ROWS*DATA_W-1:0] in_vec;
    logic                   out_valid;
    logic [COLS*ACC_W-1:0]  out_vec;
    logic                   busy;

    modport master (
        output wt_valid, wt_row, in_valid, in_vec,
        input  wt_ready, in_ready, out_valid, out_vec, busy
    );

    modport slave (
        input  wt_valid, wt_row, in_valid, in_vec,
        output wt_ready, in_ready, out_valid, out_vec, busy
    );
endinterface

// File: rtl/ws_systolic_array.sv
// ROWS x COLS weight-stationary systolic matrix-vector engine.
// Define SA_SIGNED_EN for two's-complement operands (default unsigned).
module ws_systolic_array #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input logic                clk,
    input logic                rst_n,
    ws_systolic_array_if.slave bus
);
    localparam int LAT    = ROWS + COLS;
    localparam int CNT_W  = $clog2(LAT + 1);
    localparam int BEAT_W = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic [CNT_W-1:0]  inflight;
    logic              wt_ready, in_ready;
    logic              wt_fire, in_fire;
    logic [LAT-2:0]    vld;
    logic              out_valid;
    logic [COLS*ACC_W-1:0] out_vec;

    logic [DATA_W-1:0] w_q   [ROWS][COLS];
    logic [DATA_W-1:0] a_in  [ROWS][COLS];
    logic [ACC_W-1:0]  p_out [ROWS][COLS];
    logic [ACC_W-1:0]  res   [COLS];

    // Product widened to the accumulator; the low 2*DATA_W bits of the
    // product of extended operands are exact in both number systems.
    function automatic logic [ACC_W-1:0] mul(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [2*DATA_W-1:0] p;
`ifdef SA_SIGNED_EN
        p = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
`else
        p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        return {{(ACC_W-2*DATA_W){1'b0}}, p};
`endif
    endfunction

    assign wt_fire       = bus.wt_valid && wt_ready;
    assign in_fire       = bus.in_valid && in_ready;
    assign bus.wt_ready  = wt_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_vec   = out_vec;
    assign bus.busy      = (inflight != '0);

    // Control state and weight beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    // Next state and handshake readiness; a weight beat beats a vector
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        wt_ready  = 1'b0;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                wt_ready = 1'b1;
                if (bus.wt_valid) begin
                    state_nxt = LOAD;
                    beat_nxt  = BEAT_W'(1);
                end
            end
            LOAD: begin
                wt_ready = 1'b1;
                if (bus.wt_valid) begin
                    if (beat == BEAT_W'(ROWS - 1)) begin
                        state_nxt = RUN;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat + BEAT_W'(1);
                    end
                end
            end
            RUN: begin
                wt_ready = (inflight == '0);
                in_ready = !bus.wt_valid;
                if (bus.wt_valid && inflight == '0) begin
                    state_nxt = LOAD;
                    beat_nxt  = BEAT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

    // Weight rows shift down one row per accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    w_q[r][c] <= '0;
        end else if (wt_fire) begin
            for (int c = 0; c < COLS; c++)
                w_q[0][c] <= bus.wt_row[c*DATA_W +: DATA_W];
            for (int r = 1; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    w_q[r][c] <= w_q[r-1][c];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic [DATA_W-1:0] x;
        assign x = in_fire ? bus.in_vec[r*DATA_W +: DATA_W] : '0;
        if (r == 0) begin : g_direct
            assign a_in[r][0] = x;
        end else begin : g_dly
            logic [DATA_W-1:0] sk [r];
            // Delay row r by r cycles to meet the partial-sum wavefront
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < r; k++) sk[k] <= '0;
                end else begin
                    sk[0] <= x;
                    for (int k = 1; k < r; k++) sk[k] <= sk[k-1];
                end
            end
            assign a_in[r][0] = sk[r-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe
            logic [ACC_W-1:0] ps, ps_in;
            if (r == 0) begin : g_top
                assign ps_in = '0;
            end else begin : g_mid
                assign ps_in = p_out[r-1][c];
            end
            // Multiply-accumulate into the partial sum flowing down
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ps <= '0;
                else        ps <= ps_in + mul(a_in[r][c], w_q[r][c]);
            end
            assign p_out[r][c] = ps;
            if (c < COLS - 1) begin : g_fwd
                logic [DATA_W-1:0] d;
                // Pass the operand one column to the right
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) d <= '0;
                    else        d <= a_in[r][c];
                end
                assign a_in[r][c+1] = d;
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_dsk
        if (c == COLS - 1) begin : g_last
            assign res[c] = p_out[ROWS-1][c];
        end else begin : g_dly
            localparam int D = COLS - 1 - c;
            logic [ACC_W-1:0] ds [D];
            // Hold early columns until the last column catches up
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) ds[k] <= '0;
                end else begin
                    ds[0] <= p_out[ROWS-1][c];
                    for (int k = 1; k < D; k++) ds[k] <= ds[k-1];
                end
            end
            assign res[c] = ds[D-1];
        end
    end

    // Valid bit follows each accepted vector through the fixed latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld <= '0;
        else        vld <= {vld[LAT-3:0], in_fire};
    end

    // Capture aligned results; hold the last vector between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
        end else begin
            out_valid <= vld[LAT-2];
            if (vld[LAT-2])
                for (int c = 0; c < COLS; c++)
                    out_vec[c*ACC_W +: ACC_W] <= res[c];
        end
    end

    // Vectors accepted but not yet emitted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({in_fire, out_valid})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_ws_systolic_array.sv
// Bench for ws_systolic_array (4x4, 8-bit operands, 32-bit sums).
// Expected signed/unsigned results follow SA_SIGNED_EN.
module tb_ws_systolic_array;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int LAT    = ROWS + COLS;

    typedef logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] wmat_t;
    typedef logic [ROWS-1:0][DATA_W-1:0]           ivec_t;
    typedef logic [COLS-1:0][ACC_W-1:0]            ovec_t;

    typedef struct packed {
        wmat_t w;
        ivec_t x;
        ovec_t y;
    } vec_t;

    typedef struct packed {
        ovec_t       y;
        logic [31:0] due;
    } sb_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    n_out = 0;
    int    n_pulse = 0;
    wmat_t wm;
    sb_t   sb [$];
    sb_t   e;
    sb_t   ne;
    vec_t  tbl [4];

    always #5 clk = ~clk;

    ws_systolic_array_if #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)
    ) bus ();

    ws_systolic_array #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic ovec_t model(input wmat_t w, input ivec_t x);
        ovec_t  y;
        longint acc;
        for (int c = 0; c < COLS; c++) begin
            acc = 0;
            for (int r = 0; r < ROWS; r++) begin
`ifdef SA_SIGNED_EN
                acc += longint'($signed(x[r])) * longint'($signed(w[r][c]));
`else
                acc += longint'(x[r]) * longint'(w[r][c]);
`endif
            end
            y[c] = acc[ACC_W-1:0];
        end
        return y;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                ne.y   = model(wm, bus.in_vec);
                ne.due = cyc + LAT;
                sb.push_back(ne);
            end
            if (bus.out_valid) begin
                n_pulse++;
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_out++;
                    chk("sb_value", bus.out_vec, e.y);
                    chk("sb_latency", cyc, e.due);
                end
            end
        end
    end

    task automatic send_beat(input logic [COLS*DATA_W-1:0] row);
        int n = 0;
        bus.wt_valid = 1'b1;
        bus.wt_row   = row;
        @(negedge clk);
        while (!bus.wt_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.wt_ready) chk("wt_ready_timeout", bus.wt_ready, 1);
        @(posedge clk);
        #1;
        bus.wt_valid = 1'b0;
    endtask

    task automatic load_w(input wmat_t w);
        for (int k = 0; k < ROWS; k++) send_beat(w[ROWS-1-k]);
        wm = w;
    endtask

    task automatic send_vec(input ivec_t x);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_vec   = x;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("in_ready_timeout", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((bus.busy || sb.size() != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain_busy", bus.busy, 0);
        chk("drain_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic ivec_t rnd_vec();
        ivec_t v;
        for (int r = 0; r < ROWS; r++) v[r] = DATA_W'($urandom_range(0, 255));
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int    busy_n, ov_at, base, bad, n;
        ivec_t nv;

        bus.wt_valid = 1'b0;
        bus.wt_row   = '0;
        bus.in_valid = 1'b0;
        bus.in_vec   = '0;
        wm           = '0;
        rst_n        = 1'b0;

        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                tbl[0].w[r][c] = (r == c) ? 8'd1 : 8'd0;
                tbl[1].w[r][c] = 8'd1;
                tbl[2].w[r][c] = DATA_W'(r + c);
                tbl[3].w[r][c] = 8'hFF;
            end
            tbl[0].x[r] = DATA_W'(r + 1);
            tbl[1].x[r] = DATA_W'(r + 1);
            tbl[2].x[r] = 8'd1;
            tbl[3].x[r] = 8'h80;
        end
        tbl[0].y = {32'd4, 32'd3, 32'd2, 32'd1};
        tbl[1].y = {32'd10, 32'd10, 32'd10, 32'd10};
        tbl[2].y = {32'd18, 32'd14, 32'd10, 32'd6};
`ifdef SA_SIGNED_EN
        tbl[3].y = {32'd512, 32'd512, 32'd512, 32'd512};
`else
        tbl[3].y = {32'd130560, 32'd130560, 32'd130560, 32'd130560};
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vec", bus.out_vec, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wt_ready", bus.wt_ready, 1);
        chk("rst_in_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            load_w(tbl[i].w);
            send_vec(tbl[i].x);
            busy_n = 0;
            ov_at  = -1;
            for (int k = 0; k < LAT + 2; k++) begin
                @(negedge clk);
                if (bus.busy) busy_n++;
                if (bus.out_valid && ov_at < 0) begin
                    ov_at = k;
                    chk("tbl_value", bus.out_vec, tbl[i].y);
                end
            end
            chk("tbl_busy_cycles", busy_n, LAT);
            chk("tbl_latency", ov_at, LAT - 1);
            @(posedge clk);
            #1;
        end

        load_w(tbl[2].w);
        base = n_out;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) begin
                @(posedge clk);
                #1;
            end
            send_vec(rnd_vec());
        end
        drain();
        chk("stream_pulses", n_out - base, 10);

        load_w(tbl[0].w);
        base = n_out;
        for (int i = 0; i < 5; i++) send_vec(rnd_vec());
        nv           = rnd_vec();
        bus.in_valid = 1'b1;
        bus.in_vec   = nv;
        bus.wt_valid = 1'b1;
        bus.wt_row   = tbl[1].w[ROWS-1];
        #1;
        chk("reload_in_ready_drop", bus.in_ready, 0);
        bad = 0;
        n   = 0;
        @(negedge clk);
        while (!bus.wt_ready && n < 100) begin
            if (bus.in_ready) bad++;
            n++;
            @(negedge clk);
        end
        chk("reload_wt_ready_after_5", n_out - base, 5);
        for (int k = 0; k < ROWS; k++) begin
            bus.wt_row = tbl[1].w[ROWS-1-k];
            n = 0;
            while (!bus.wt_ready && n < 100) begin
                n++;
                @(negedge clk);
            end
            if (bus.in_ready) bad++;
            @(posedge clk);
            #1;
            if (k < ROWS - 1) @(negedge clk);
        end
        bus.wt_valid = 1'b0;
        wm = tbl[1].w;
        chk("reload_in_ready_low", bad, 0);
        @(negedge clk);
        chk("reload_resume_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();
        chk("reload_pulses", n_out - base, 6);

        load_w(tbl[1].w);
        for (int i = 0; i < 3; i++) send_vec(rnd_vec());
        bus.in_valid = 1'b1;
        bus.in_vec   = rnd_vec();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_vec", bus.out_vec, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        chk("arst_wt_ready", bus.wt_ready, 1);
        sb.delete();
        base = n_pulse;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk("arst_no_stale", n_pulse - base, 0);
        chk("arst_still_idle", bus.in_ready, 0);
        bus.in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
